// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified instruction/data memory port between the fetch stage and
// the LDUR/STUR path. Each access is sequenced IDLE -> FETCH/DATA -> DONE. On
// contention, grants alternate between the two requesters. A watchdog aborts
// accesses that never see mem_ready. Misaligned data addresses are rejected
// without issuing a memory cycle.
//
// Ports
//   clock, reset            : system clock, synchronous active-high reset
//   if_req/if_addr          : fetch request (held until if_ack) and PC
//   if_ack/if_instr         : one-cycle completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata : data request (held until d_ack)
//   d_ack/d_rdata           : one-cycle completion pulse and load data
//   err                     : qualifies either ack (misaligned or timeout)
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory port drive
//   mem_rdata/mem_ready     : memory response
//   stall                   : combinational pipeline freeze
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [31:0]           if_instr,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  stall
);

   localparam int WDOG_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(7);

   typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;
   typedef enum logic {GNT_FETCH, GNT_DATA} gnt_t;

   state_t                state_q, state_d;
   gnt_t                  last_grant_q, last_grant_d;
   logic [WDOG_W-1:0]     wdog_q, wdog_d;
   logic                  addr2_q, addr2_d;
   logic                  we_q, we_d;
   logic                  if_ack_q, if_ack_d;
   logic [31:0]           if_instr_q, if_instr_d;
   logic                  d_ack_q, d_ack_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  err_q, err_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  grant_f, grant_d;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wdog_d       = wdog_q;
      addr2_d      = addr2_q;
      we_d         = we_q;
      if_ack_d     = 1'b0;
      if_instr_d   = if_instr_q;
      d_ack_d      = 1'b0;
      d_rdata_d    = d_rdata_q;
      err_d        = 1'b0;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      grant_f      = 1'b0;
      grant_d      = 1'b0;

      case (state_q)
         IDLE: begin
            // On contention data wins unless it was the last one served.
            if (d_req && (!if_req || last_grant_q == GNT_FETCH)) grant_d = 1'b1;
            else if (if_req)                                      grant_f = 1'b1;
         end
         FETCH, DATA: begin
            if (mem_ready || wdog_q == WDOG_W'(TIMEOUT)) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               err_d     = ~mem_ready;
               if (state_q == FETCH) begin
                  if_ack_d   = 1'b1;
                  if_instr_d = !mem_ready ? '0 :
                               addr2_q    ? mem_rdata[63:32] : mem_rdata[31:0];
               end else begin
                  d_ack_d = 1'b1;
                  if (!we_q) d_rdata_d = mem_ready ? mem_rdata : '0;
               end
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         DONE: begin
            // The requester just acked still has its req high; only the
            // other side may be granted straight from here.
            state_d = IDLE;
            if (last_grant_q == GNT_FETCH) grant_d = d_req;
            else                           grant_f = if_req;
         end
         default: state_d = IDLE;
      endcase

      if (grant_f) begin
         state_d      = FETCH;
         last_grant_d = GNT_FETCH;
         wdog_d       = '0;
         addr2_d      = if_addr[2];
         we_d         = 1'b0;
         mem_req_d    = 1'b1;
         mem_we_d     = 1'b0;
         mem_addr_d   = if_addr & WORD_MASK;
      end

      if (grant_d) begin
         last_grant_d = GNT_DATA;
         wdog_d       = '0;
         addr2_d      = d_addr[2];
         we_d         = d_we;
         if (d_addr[2:0] != 3'b000) begin
            // Misaligned: complete immediately with an error, no memory cycle.
            state_d = DONE;
            d_ack_d = 1'b1;
            err_d   = 1'b1;
            if (!d_we) d_rdata_d = '0;
         end else begin
            state_d     = DATA;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr & WORD_MASK;
            mem_wdata_d = d_wdata;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_FETCH;
         wdog_q       <= '0;
         addr2_q      <= 1'b0;
         we_q         <= 1'b0;
         if_ack_q     <= 1'b0;
         if_instr_q   <= '0;
         d_ack_q      <= 1'b0;
         d_rdata_q    <= '0;
         err_q        <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wdog_q       <= wdog_d;
         addr2_q      <= addr2_d;
         we_q         <= we_d;
         if_ack_q     <= if_ack_d;
         if_instr_q   <= if_instr_d;
         d_ack_q      <= d_ack_d;
         d_rdata_q    <= d_rdata_d;
         err_q        <= err_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign if_ack    = if_ack_q;
   assign if_instr  = if_instr_q;
   assign d_ack     = d_ack_q;
   assign d_rdata   = d_rdata_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam logic [63:0] GARB = 64'hDEAD_BEEF_DEAD_BEEF;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [63:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_instr;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [63:0] d_addr = '0;
   logic [63:0] d_wdata = '0;
   logic        d_ack;
   logic [63:0] d_rdata;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ready;
   logic        stall;

   mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(8)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall(stall)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          fetch;
      bit          chk_data;
      logic [63:0] data;
      bit          err;
   } exp_t;
   exp_t sb[$];
   logic [63:0] last_rdata = '0;

   // Memory model: responds wait_n cycles into an access (-1 = never).
   logic [63:0] mem [longint unsigned];
   int wait_n = 0;
   int mcnt = 0;
   longint unsigned mkey;

   initial begin
      mem_ready = 1'b0;
      mem_rdata = GARB;
      forever begin
         @(negedge clock);
         if (mem_req === 1'b1) begin
            if (wait_n >= 0 && mcnt == wait_n) begin
               mkey = mem_addr >> 3;
               if (mem_we) mem[mkey] = mem_wdata;
               mem_ready = 1'b1;
               mem_rdata = mem.exists(mkey) ? mem[mkey] : '0;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = GARB;
            end
            mcnt++;
         end else begin
            mcnt = 0;
            mem_ready = 1'b0;
            mem_rdata = GARB;
         end
      end
   end

   // Scoreboard: every ack pops the oldest expected completion.
   exp_t        mon_e;
   logic [63:0] mon_data;
   always @(negedge clock) begin
      if (if_ack === 1'b1 || d_ack === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_ack: if_ack=%0b d_ack=%0b, required no ack", if_ack, d_ack);
         end else begin
            mon_e = sb.pop_front();
            mon_data = if_ack ? {32'h0, if_instr} : d_rdata;
            if (if_ack !== mon_e.fetch || d_ack !== !mon_e.fetch || err !== mon_e.err ||
                (mon_e.chk_data && mon_data !== mon_e.data)) begin
               failures++;
               $display("FAIL sb_ack: got if_ack=%0b d_ack=%0b err=%0b data=%h, required if_ack=%0b d_ack=%0b err=%0b data=%h",
                        if_ack, d_ack, err, mon_data, mon_e.fetch, !mon_e.fetch, mon_e.err, mon_e.data);
            end
         end
      end
   end

   function automatic exp_t mk(bit f, bit c, logic [63:0] d, bit e);
      exp_t r;
      r.fetch = f; r.chk_data = c; r.data = d; r.err = e;
      return r;
   endfunction

   // Drives one request, holds it until its ack, and reports timing.
   task automatic run_req(input bit fetch, input logic [63:0] addr, input bit we,
                          input logic [63:0] wdata, input int limit,
                          output int lat, output int stall_cnt, output int mreq_cnt,
                          output bit saw_we, output logic [63:0] seen_addr);
      lat = -1; stall_cnt = 0; mreq_cnt = 0; saw_we = 1'b0; seen_addr = '0;
      @(posedge clock); #1;
      if (fetch) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end
      for (int k = 0; k <= limit; k++) begin
         @(negedge clock);
         if (stall) stall_cnt++;
         if (mem_req) begin
            mreq_cnt++;
            seen_addr = mem_addr;
            if (mem_we) saw_we = 1'b1;
         end
         if ((fetch && if_ack) || (!fetch && d_ack)) begin
            lat = k;
            break;
         end
      end
      @(posedge clock); #1;
      if (fetch) if_req = 1'b0; else d_req = 1'b0;
   endtask

   int lat, scnt, mcnt_o;
   bit swe;
   logic [63:0] saddr;

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({if_ack, d_ack, err, mem_req, mem_we, stall} !== 6'b0 || if_instr !== 32'h0 ||
          d_rdata !== 64'h0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
         failures++;
         $display("FAIL reset_values: acks/err/req/we/stall=%b instr=%h rdata=%h addr=%h wdata=%h, required all zero",
                  {if_ack, d_ack, err, mem_req, mem_we, stall}, if_instr, d_rdata, mem_addr, mem_wdata);
      end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_fetch;
      mem[64'h0] = 64'h1101_0004_D280_3208;
      wait_n = 0;
      sb.push_back(mk(1, 1, 64'h1101_0004, 0));
      run_req(1, 64'h4, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 2 || scnt !== 2 || mcnt_o !== 1 || saddr !== 64'h0 || swe !== 1'b0) begin
         failures++;
         $display("FAIL fetch_hi: lat=%0d stall=%0d mreq=%0d addr=%h we=%0b, required 2 2 1 0 0", lat, scnt, mcnt_o, saddr, swe);
      end
      sb.push_back(mk(1, 1, 64'hD280_3208, 0));
      run_req(1, 64'h0, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 2) begin
         failures++;
         $display("FAIL fetch_lo_latency: got %0d, required 2", lat);
      end
   endtask

   task automatic test_load_store;
      sb.push_back(mk(0, 1, last_rdata, 0));
      run_req(0, 64'h4B0, 1, 64'h64, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 2 || swe !== 1'b1 || saddr !== 64'h4B0 || mem[64'h4B0 >> 3] !== 64'h64) begin
         failures++;
         $display("FAIL store_0x4b0: lat=%0d we=%0b addr=%h memword=%h, required 2 1 4b0 64", lat, swe, saddr, mem[64'h4B0 >> 3]);
      end
      mem[64'h190 >> 3] = 64'h64;
      sb.push_back(mk(0, 1, 64'h64, 0));
      last_rdata = 64'h64;
      run_req(0, 64'h190, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 2 || swe !== 1'b0 || saddr !== 64'h190) begin
         failures++;
         $display("FAIL load_0x190: lat=%0d we=%0b addr=%h, required 2 0 190", lat, swe, saddr);
      end
      sb.push_back(mk(0, 1, last_rdata, 0));
      run_req(0, 64'h4B8, 1, 64'hA5A5_0000_1234_5678, 20, lat, scnt, mcnt_o, swe, saddr);
      sb.push_back(mk(0, 1, 64'hA5A5_0000_1234_5678, 0));
      last_rdata = 64'hA5A5_0000_1234_5678;
      run_req(0, 64'h4B8, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (mem[64'h4B8 >> 3] !== 64'hA5A5_0000_1234_5678) begin
         failures++;
         $display("FAIL store_0x4b8_data: memword=%h, required a5a5000012345678", mem[64'h4B8 >> 3]);
      end
   endtask

   task automatic both_req(output int fa, output int da);
      bit df, dd;
      fa = -1; da = -1;
      @(posedge clock); #1;
      if_req = 1'b1; if_addr = 64'h104;
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         df = if_ack; dd = d_ack;
         if (df && fa < 0) fa = k;
         if (dd && da < 0) da = k;
         @(posedge clock); #1;
         if (df) if_req = 1'b0;
         if (dd) d_req = 1'b0;
         if (fa >= 0 && da >= 0) break;
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_contention;
      int fa, da;
      mem[64'h100 >> 3] = 64'hCAFE_0001_8B02_0020;
      mem[64'h200 >> 3] = 64'h0123_4567_89AB_CDEF;
      // last grant was data (loads above), so clear that with a fetch first
      sb.push_back(mk(1, 1, 64'hCAFE_0001, 0));
      run_req(1, 64'h104, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      sb.push_back(mk(0, 1, 64'h0123_4567_89AB_CDEF, 0));
      sb.push_back(mk(1, 1, 64'hCAFE_0001, 0));
      last_rdata = 64'h0123_4567_89AB_CDEF;
      both_req(fa, da);
      checks++;
      if (da !== 2 || fa !== 4) begin
         failures++;
         $display("FAIL contention_data_first: d_ack@%0d if_ack@%0d, required 2 4", da, fa);
      end
      sb.push_back(mk(0, 1, 64'h0123_4567_89AB_CDEF, 0));
      run_req(0, 64'h200, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      sb.push_back(mk(1, 1, 64'hCAFE_0001, 0));
      sb.push_back(mk(0, 1, 64'h0123_4567_89AB_CDEF, 0));
      both_req(fa, da);
      checks++;
      if (fa !== 2 || da !== 4) begin
         failures++;
         $display("FAIL contention_fetch_first: if_ack@%0d d_ack@%0d, required 2 4", fa, da);
      end
   endtask

   task automatic test_back_to_back;
      int a1, a2;
      a1 = -1; a2 = -1;
      sb.push_back(mk(1, 1, 64'h8B02_0020, 0));
      sb.push_back(mk(1, 1, 64'h8B02_0020, 0));
      @(posedge clock); #1;
      if_req = 1'b1; if_addr = 64'h100;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (if_ack) begin
            if (a1 < 0) a1 = k; else a2 = k;
         end
         if (a2 >= 0) break;
      end
      @(posedge clock); #1;
      if_req = 1'b0;
      checks++;
      if (a1 !== 2 || a2 !== 5) begin
         failures++;
         $display("FAIL back_to_back_same: acks@%0d,%0d, required 2,5", a1, a2);
      end
   endtask

   task automatic test_wait_states;
      wait_n = 3;
      sb.push_back(mk(1, 1, 64'hCAFE_0001, 0));
      run_req(1, 64'h104, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 5 || mcnt_o !== 4) begin
         failures++;
         $display("FAIL wait3_fetch: lat=%0d mreq=%0d, required 5 4", lat, mcnt_o);
      end
      wait_n = 1;
      sb.push_back(mk(0, 1, 64'h64, 0));
      last_rdata = 64'h64;
      run_req(0, 64'h190, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 3) begin
         failures++;
         $display("FAIL wait1_load: lat=%0d, required 3", lat);
      end
      wait_n = 0;
   endtask

   task automatic test_timeout;
      wait_n = -1;
      sb.push_back(mk(1, 1, 64'h0, 1));
      run_req(1, 64'h104, 0, '0, 30, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 10 || mcnt_o !== 9 || scnt !== 10) begin
         failures++;
         $display("FAIL timeout_fetch: lat=%0d mreq=%0d stall=%0d, required 10 9 10", lat, mcnt_o, scnt);
      end
      @(negedge clock);
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("FAIL timeout_mem_req_after: got %0b, required 0", mem_req);
      end
      sb.push_back(mk(0, 1, 64'h0, 1));
      last_rdata = 64'h0;
      run_req(0, 64'h200, 0, '0, 30, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 10) begin
         failures++;
         $display("FAIL timeout_load: lat=%0d, required 10", lat);
      end
      wait_n = 0;
   endtask

   task automatic test_misaligned;
      sb.push_back(mk(0, 1, 64'h64, 0));
      run_req(0, 64'h190, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      sb.push_back(mk(0, 1, 64'h0, 1));
      last_rdata = 64'h0;
      run_req(0, 64'h193, 0, '0, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 1 || mcnt_o !== 0) begin
         failures++;
         $display("FAIL misaligned_load: lat=%0d mreq=%0d, required 1 0", lat, mcnt_o);
      end
      sb.push_back(mk(0, 0, 64'h0, 1));
      run_req(0, 64'h4B4, 1, 64'hFFFF, 20, lat, scnt, mcnt_o, swe, saddr);
      checks++;
      if (lat !== 1 || mcnt_o !== 0 || mem[64'h4B0 >> 3] !== 64'h64) begin
         failures++;
         $display("FAIL misaligned_store: lat=%0d mreq=%0d memword=%h, required 1 0 64", lat, mcnt_o, mem[64'h4B0 >> 3]);
      end
   endtask

   task automatic test_reset_mid;
      wait_n = -1;
      @(posedge clock); #1;
      if_req = 1'b1; if_addr = 64'h104;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (mem_req !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_started: mem_req=%0b, required 1", mem_req);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (mem_req !== 1'b0 || if_ack !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_abort: mem_req=%0b if_ack=%0b, required 0 0", mem_req, if_ack);
      end
      wait_n = 0;
      sb.push_back(mk(1, 1, 64'hCAFE_0001, 0));
      @(posedge clock); #1;
      reset = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (if_ack) begin
            lat = k;
            break;
         end
      end
      @(posedge clock); #1;
      if_req = 1'b0;
      checks++;
      if (lat !== 2) begin
         failures++;
         $display("FAIL reset_mid_restart: lat=%0d, required 2", lat);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_load_store();
      test_contention();
      test_back_to_back();
      test_wait_states();
      test_timeout();
      test_misaligned();
      test_reset_mid();
      repeat (3) @(posedge clock);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d expected acks outstanding, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and access sequencer for the 64-bit LEGv8 datapath. It shares one unified instruction/data memory port between the instruction-fetch stage and the load/store path (LDUR/STUR). It sequences each access through a small state machine and returns fetched instructions to the control unit and load data to the register file. It also drives a `stall` signal that freezes PC and pipeline registers while an access is outstanding.

## Interface

Parameters:
- `ADDR_WIDTH`, 64, byte address width
- `DATA_WIDTH`, 64, memory word width
- `TIMEOUT`, 255, max cycles waiting on `mem_ready` before an access is aborted

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  ADDR_WIDTH  fetch byte address (PC)
- `if_ack`  out  1  one-cycle pulse: `if_instr` valid
- `if_instr`  out  32  fetched instruction
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store (STUR), 0 = load (LDUR)
- `d_addr`  in  ADDR_WIDTH  data byte address
- `d_wdata`  in  DATA_WIDTH  store data
- `d_ack`  out  1  one-cycle pulse: access complete, `d_rdata` valid on loads
- `d_rdata`  out  DATA_WIDTH  load data
- `err`  out  1  valid with either ack: misaligned data address or timeout
- `mem_req`  out  1  memory access active
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  word-aligned address `{addr[63:3],3'b000}`
- `mem_wdata`  out  DATA_WIDTH  write data
- `mem_rdata`  in  DATA_WIDTH  read data, valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes the current access this cycle
- `stall`  out  1  combinational: `(if_req & ~if_ack) | (d_req & ~d_ack)`

The clock is `clock`; reset is `reset`, synchronous and active-high.

## Operation

- States: IDLE, FETCH, DATA, DONE. Internal `last_grant` records the last granted requester (fetch/data). `wdog` is an 8-bit-min timeout counter.
- IDLE:
  - Only `d_req` pending → DATA.
  - Only `if_req` pending → FETCH.
  - Both pending → data wins unless `last_grant`=data, then fetch wins (alternating).
  - On grant, latch address, `d_we` and `d_wdata`. Set `last_grant` and clear `wdog`.
- FETCH/DATA:
  - `mem_req`=1. `mem_we`=latched `d_we` in DATA, 0 in FETCH. `mem_addr`/`mem_wdata` come from the latches.
  - `wdog` increments each cycle.
  - On `mem_ready`: capture result, go to DONE.
  - If `wdog`=TIMEOUT with no `mem_ready`: go to DONE with `err`=1, data outputs 0.
- Fetch result: `if_instr` = latched addr[2] ? `mem_rdata[63:32]` : `mem_rdata[31:0]`.
- Data misalignment (`d_addr[2:0]`≠0):
  - Detected at grant; no memory cycle is issued (`mem_req` stays 0).
  - Next state is DONE with `err`=1 and `d_rdata`=0. Stores write nothing.
- DONE:
  - Pulse the matching ack (`if_ack` or `d_ack`) with registered data and `err`.
  - The just-acked requester is ignored this cycle, because its req is still high.
  - If the other requester is pending, grant it directly (→ FETCH/DATA). Otherwise → IDLE.
- Stores: `d_rdata` is held at its previous value; only `d_ack`/`err` are meaningful.

## Timing

- Reset values: state IDLE, `last_grant`=fetch, `if_ack`=`d_ack`=`err`=`mem_req`=`mem_we`=0, `if_instr`=0, `d_rdata`=0, `mem_addr`=`mem_wdata`=0.
- Reset mid-access abandons the access: `mem_req` is 0 from the next edge and no ack is issued. Requests seen during reset are ignored.
- With zero memory wait (`mem_ready` in the first FETCH/DATA cycle):
  - Cycle 0: req seen in IDLE.
  - Cycle 1: `mem_req`=1.
  - Cycle 2: ack.
  - Request-to-ack latency is 2 cycles; each wait cycle adds 1.
- Back-to-back alternating requesters: one access per 2 cycles (DONE grants directly). The same requester re-requesting: one access per 3 cycles.
- Misaligned data: ack 1 cycle after grant.
- Timeout: ack at TIMEOUT+2 cycles after grant.
- `mem_*` outputs are registered/state-decoded and glitch-free. `stall` is the only combinational output.

## Test plan

- Fetch only: `if_addr`=0x4, `mem_rdata`=0x1101_0004_D280_3208 with ready at first cycle → `if_ack` 2 cycles after request, `if_instr`=0x1101_0004, `err`=0, `stall` high for exactly 2 cycles.
- Load/store: STUR `d_addr`=0x4B0, `d_wdata`=0x64 → `mem_we`=1, `mem_addr`=0x4B0, `d_ack`. Then LDUR 0x190 with `mem_rdata`=0x64 → `d_rdata`=0x64.
- Contention:
  - `if_req` and `d_req` asserted in the same cycle after reset → data granted first, fetch granted from DONE.
  - Repeat both → fetch granted first (alternation).
- Wait states and timeout:
  - `mem_ready` delayed 3 cycles → ack at cycle 5.
  - `mem_ready` never asserted with TIMEOUT=8 → ack with `err`=1 at cycle 10, `mem_req` then 0.
- Misaligned: `d_addr`=0x193 → no `mem_req`, `d_ack` + `err`=1 one cycle after grant.
- Reset in FETCH wait cycle → next edge: IDLE, `mem_req`=0, no `if_ack`. After reset deasserts, a held `if_req` restarts the access normally.
